// File: rtl/cache_tag_if.sv
// Request/response bundle between the cache controller and the tag array.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready; req_ready never depends on req_valid.
interface cache_tag_if #(
  parameter int NUM_WAY = 8,
  parameter int ENT_W   = 22
);
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_wr;
  logic [31:0]              req_addr;
  logic [NUM_WAY-1:0]       req_way_mask;
  logic [NUM_WAY*ENT_W-1:0] req_wdata;
  logic                     rsp_valid;
  logic                     rsp_hit;
  logic [NUM_WAY-1:0]       rsp_hit_way;
  logic                     rsp_dirty;
  logic                     rsp_multi_hit;
  logic [NUM_WAY*ENT_W-1:0] rsp_entries;
  logic                     flush_req;
  logic                     busy;
  logic                     flush_done;

  modport master (
    output req_valid, req_wr, req_addr, req_way_mask, req_wdata, flush_req,
    input  req_ready, rsp_valid, rsp_hit, rsp_hit_way, rsp_dirty, rsp_multi_hit,
           rsp_entries, busy, flush_done
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_way_mask, req_wdata, flush_req,
    output req_ready, rsp_valid, rsp_hit, rsp_hit_way, rsp_dirty, rsp_multi_hit,
           rsp_entries, busy, flush_done
  );
endinterface

// File: rtl/cache_tag_array.sv
// Banked {valid, dirty, tag} store with registered tag compare and an init/flush
// sequencer that invalidates one row of every bank per cycle.
module cache_tag_array #(
  parameter int NUM_WAY  = 8,
  parameter int NUM_SET  = 128,
  parameter int NUM_BANK = 2,
  parameter int OFFSET_W = 5
) (
  input  logic       clk,
  input  logic       rst,
  cache_tag_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int INDEX_W = $clog2(NUM_SET);
  localparam int TAG_W   = 32 - INDEX_W - OFFSET_W;
  localparam int ENT_W   = TAG_W + 2;
  localparam int ROWS    = NUM_SET / NUM_BANK;
  localparam int ROW_W   = $clog2(ROWS);
  localparam int BANK_W  = $clog2(NUM_BANK);
  localparam int ROW_SW  = (ROW_W > 0) ? ROW_W : 1;
  localparam int BANK_SW = (BANK_W > 0) ? BANK_W : 1;

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_FLUSH = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [ROW_SW-1:0]  cnt_q, cnt_d;
  logic               flush_done_q, flush_done_d;
  logic               clear_en;

  logic [INDEX_W-1:0] req_index;
  logic [ROW_SW-1:0]  req_row;
  logic [BANK_SW-1:0] req_bank;
  logic [TAG_W-1:0]   req_tag;
  logic               xfer, wr_en, rd_en;

  logic               rsp_valid_q;
  logic [BANK_SW-1:0] bank_q;
  logic [TAG_W-1:0]   tag_q;
  logic [NUM_WAY*ENT_W-1:0] rd_data [NUM_BANK];
  logic [NUM_WAY*ENT_W-1:0] sel_entries;
  logic [NUM_WAY-1:0] match;
  logic               hit_dirty;
  logic               unused_offset_bits;

  assign req_index = bus.req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign req_row   = ROW_SW'(req_index % ROWS);
  assign req_bank  = BANK_SW'(req_index / ROWS);
  assign req_tag   = bus.req_addr[31:32-TAG_W];
  assign unused_offset_bits = ^bus.req_addr[OFFSET_W-1:0];

  assign xfer  = bus.req_valid && (state_q == ST_IDLE);
  assign wr_en = xfer && bus.req_wr;
  assign rd_en = xfer && !bus.req_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Init and flush share the row sweep; only a flush reports completion.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_done_d = 1'b0;
    clear_en     = 1'b0;
    case (state_q)
      ST_INIT, ST_FLUSH: begin
        clear_en = 1'b1;
        cnt_d    = cnt_q + ROW_SW'(1);
        if (cnt_q == ROW_SW'(ROWS - 1)) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          flush_done_d = (state_q == ST_FLUSH);
        end
      end
      ST_IDLE: begin
        if (bus.flush_req) begin
          state_d = ST_FLUSH;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic [ENT_W-1:0]         mem [ROWS][NUM_WAY];
    logic [NUM_WAY*ENT_W-1:0] rd_q;
    logic                     bank_sel;

    assign bank_sel = (req_bank == BANK_SW'(b));

    always_ff @(posedge clk) begin
      for (int w = 0; w < NUM_WAY; w++) begin
        if (clear_en)
          mem[cnt_q][w] <= '0;
        else if (wr_en && bank_sel && bus.req_way_mask[w])
          mem[req_row][w] <= bus.req_wdata[ENT_W*w +: ENT_W];
      end
    end

    // Read register only loads on a lookup to this bank, so the held response is not disturbed.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        rd_q <= '0;
      end else if (rd_en && bank_sel) begin
        for (int w = 0; w < NUM_WAY; w++)
          rd_q[ENT_W*w +: ENT_W] <= mem[req_row][w];
      end
    end

    assign rd_data[b] = rd_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      bank_q      <= '0;
      tag_q       <= '0;
    end else begin
      rsp_valid_q <= rd_en;
      if (rd_en) begin
        bank_q <= req_bank;
        tag_q  <= req_tag;
      end
    end
  end

  // Descending scan leaves the dirty bit of the lowest matching way.
  always_comb begin
    sel_entries = rd_data[bank_q];
    match       = '0;
    hit_dirty   = 1'b0;
    for (int w = NUM_WAY - 1; w >= 0; w--) begin
      match[w] = sel_entries[ENT_W*w + ENT_W - 1] && (sel_entries[ENT_W*w +: TAG_W] == tag_q);
      if (match[w]) hit_dirty = sel_entries[ENT_W*w + TAG_W];
    end
  end

  assign bus.req_ready     = (state_q == ST_IDLE);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.flush_done    = flush_done_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_hit       = |match;
  assign bus.rsp_hit_way   = match;
  assign bus.rsp_dirty     = hit_dirty;
  assign bus.rsp_multi_hit = ($countones(match) > 1);
  assign bus.rsp_entries   = sel_entries;
  assign dbg_state         = state_q;
endmodule

// File: tb/tb_cache_tag_array.sv
// Randomised bench for cache_tag_array: set-indexed reference store, per-cycle
// compare process and directed literal checks for init, banks, masks, multi-hit and flush.
module tb_cache_tag_array;
  localparam int NUM_WAY  = 8;
  localparam int NUM_SET  = 128;
  localparam int NUM_BANK = 2;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = 20;
  localparam int ENT_W    = 22;
  localparam int ROWS     = 64;
  localparam int DW       = NUM_WAY * ENT_W;
  localparam int RSP_W    = 3 + NUM_WAY + DW;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  cache_tag_if #(.NUM_WAY(NUM_WAY), .ENT_W(ENT_W)) bus ();

  cache_tag_array #(
    .NUM_WAY(NUM_WAY), .NUM_SET(NUM_SET), .NUM_BANK(NUM_BANK), .OFFSET_W(OFFSET_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [ENT_W-1:0] mdl [NUM_SET][NUM_WAY];
  int   clear_left     = ROWS;
  logic clear_is_flush = 1'b0;
  logic e_fdone        = 1'b0;
  logic e_rvalid       = 1'b0;
  logic [RSP_W-1:0] exp_q [$];
  logic [RSP_W-1:0] last_rsp = '0;

  int               m_set;
  logic [TAG_W-1:0] m_tag;
  logic [NUM_WAY-1:0] m_match;
  int               m_cnt;
  logic             m_dirty, m_found;
  logic [DW-1:0]    m_ents;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Reference: array indexed by set; any clear wipes it and blocks requests for ROWS cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      clear_left     = ROWS;
      clear_is_flush = 1'b0;
      e_fdone        = 1'b0;
      e_rvalid       = 1'b0;
      exp_q.delete();
      for (int s = 0; s < NUM_SET; s++)
        for (int w = 0; w < NUM_WAY; w++) mdl[s][w] = '0;
    end else begin
      e_fdone  = 1'b0;
      e_rvalid = 1'b0;
      if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0 && clear_is_flush) e_fdone = 1'b1;
      end else begin
        if (bus.req_valid) begin
          m_set = int'((bus.req_addr >> OFFSET_W) % NUM_SET);
          m_tag = bus.req_addr[31:32-TAG_W];
          if (bus.req_wr) begin
            for (int w = 0; w < NUM_WAY; w++)
              if (bus.req_way_mask[w]) mdl[m_set][w] = bus.req_wdata[ENT_W*w +: ENT_W];
          end else begin
            m_match = '0; m_cnt = 0; m_dirty = 1'b0; m_found = 1'b0;
            for (int w = 0; w < NUM_WAY; w++) begin
              m_ents[ENT_W*w +: ENT_W] = mdl[m_set][w];
              if (mdl[m_set][w][ENT_W-1] && mdl[m_set][w][TAG_W-1:0] == m_tag) begin
                m_match[w] = 1'b1;
                m_cnt++;
                if (!m_found) begin
                  m_dirty = mdl[m_set][w][TAG_W];
                  m_found = 1'b1;
                end
              end
            end
            exp_q.push_back({m_cnt > 0, m_cnt > 1, m_dirty, m_match, m_ents});
            e_rvalid = 1'b1;
          end
        end
        if (bus.flush_req) begin
          clear_left     = ROWS;
          clear_is_flush = 1'b1;
          for (int s = 0; s < NUM_SET; s++)
            for (int w = 0; w < NUM_WAY; w++) mdl[s][w] = '0;
        end
      end
    end
  end

  // Compare every cycle on the falling edge; response fields must hold between lookups.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst) last_rsp = '0;
      check("req_ready", bus.req_ready, clear_left == 0);
      check("busy", bus.busy, clear_left != 0);
      check("flush_done", bus.flush_done, e_fdone);
      check("rsp_valid", bus.rsp_valid, e_rvalid);
      if (e_rvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL scoreboard_empty act=0 exp=1");
        end else begin
          last_rsp = exp_q.pop_front();
        end
      end
      check("rsp_hit", bus.rsp_hit, last_rsp[RSP_W-1]);
      check("rsp_multi_hit", bus.rsp_multi_hit, last_rsp[RSP_W-2]);
      check("rsp_dirty", bus.rsp_dirty, last_rsp[RSP_W-3]);
      check("rsp_hit_way", bus.rsp_hit_way, last_rsp[DW +: NUM_WAY]);
      check("rsp_entries", bus.rsp_entries, last_rsp[DW-1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] mk_addr(input logic [TAG_W-1:0] t, input int s, input int off);
    return {t, 7'(s), 5'(off)};
  endfunction

  function automatic logic [ENT_W-1:0] mk_ent(input logic v, input logic d, input logic [TAG_W-1:0] t);
    return {v, d, t};
  endfunction

  function automatic logic [TAG_W-1:0] pick_tag();
    case ($urandom_range(0, 2))
      0:       return 20'hABCDE;
      1:       return 20'h12345;
      default: return 20'h55AA5;
    endcase
  endfunction

  function automatic int pick_set();
    case ($urandom_range(0, 6))
      0: return 2;
      1: return 5;
      2: return 69;
      3: return 10;
      4: return 127;
      5: return 64;
      default: return int'($urandom_range(0, NUM_SET - 1));
    endcase
  endfunction

  function automatic logic [DW-1:0] rnd_wdata();
    logic [DW-1:0] d;
    for (int w = 0; w < NUM_WAY; w++)
      d[ENT_W*w +: ENT_W] = mk_ent(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_tag());
    return d;
  endfunction

  task automatic drive(input logic v, input logic wr, input logic [31:0] a,
                       input logic [NUM_WAY-1:0] m, input logic [DW-1:0] d, input logic f);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush_req = 1'b0;
    n = 0;
    while (!bus.req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL ready_timeout act=%0d exp<200", n);
    end
    bus.req_valid    = v;
    bus.req_wr       = wr;
    bus.req_addr     = a;
    bus.req_way_mask = m;
    bus.req_wdata    = d;
    bus.flush_req    = f;
  endtask

  task automatic wr_req(input logic [31:0] a, input logic [NUM_WAY-1:0] m, input logic [DW-1:0] d);
    drive(1'b1, 1'b1, a, m, d, 1'b0);
  endtask

  task automatic look_check(input string nm, input logic [31:0] a, input logic eh,
                            input logic [NUM_WAY-1:0] ew, input logic em,
                            input logic cd, input logic ed);
    drive(1'b1, 1'b0, a, '0, '0, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({nm, "_valid"}, bus.rsp_valid, 1'b1);
    check({nm, "_hit"}, bus.rsp_hit, eh);
    check({nm, "_way"}, bus.rsp_hit_way, ew);
    check({nm, "_multi"}, bus.rsp_multi_hit, em);
    if (cd) check({nm, "_dirty"}, bus.rsp_dirty, ed);
  endtask

  // ---------------- main sequence ----------------
  logic [ENT_W-1:0]   saved [NUM_WAY];
  logic [DW-1:0]      wd;
  logic [NUM_WAY-1:0] vb;
  logic [TAG_W-1:0]   t;
  int n, fd, r;
  logic f;

  initial begin
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_addr = '0;
    bus.req_way_mask = '0; bus.req_wdata = '0; bus.flush_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 1'b1);
    check("reset_ready", bus.req_ready, 1'b0);
    check("reset_flush_done", bus.flush_done, 1'b0);

    // init: busy for exactly ROWS cycles after release
    rst = 1'b1;
    n = 0;
    while (bus.busy && n < 200) begin n++; @(negedge clk); end
    check("init_cycles", DW'(n), DW'(64));
    check("init_ready", bus.req_ready, 1'b1);

    look_check("init_lookup", 32'h0000_1000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < NUM_WAY; w++) vb[w] = bus.rsp_entries[ENT_W*w + ENT_W - 1];
    check("init_valid_bits", vb, 8'h00);

    // write then immediate lookup
    wd = '0;
    wd[ENT_W*2 +: ENT_W] = mk_ent(1'b1, 1'b1, 20'hABCDE);
    wr_req(32'hABCD_E040, 8'b0000_0100, wd);
    look_check("wr_lookup", 32'hABCD_E040, 1'b1, 8'b0000_0100, 1'b0, 1'b1, 1'b1);

    // bank split: set 5 in bank 0, set 69 in bank 1, same tag
    wd = '0;
    wd[ENT_W*3 +: ENT_W] = mk_ent(1'b1, 1'b0, 20'h12345);
    wr_req(mk_addr(20'h12345, 5, 0), 8'b0000_1000, wd);
    wd = '0;
    wd[ENT_W*6 +: ENT_W] = mk_ent(1'b1, 1'b1, 20'h12345);
    wr_req(mk_addr(20'h12345, 69, 31), 8'b0100_0000, wd);
    drive(1'b1, 1'b0, mk_addr(20'h12345, 5, 4), '0, '0, 1'b0);
    drive(1'b1, 1'b0, mk_addr(20'h12345, 69, 8), '0, '0, 1'b0);
    check("bank_a_way", bus.rsp_hit_way, 8'b0000_1000);
    drive(1'b1, 1'b0, mk_addr(20'h12345, 5, 12), '0, '0, 1'b0);
    check("bank_b_way", bus.rsp_hit_way, 8'b0100_0000);
    check("bank_b_dirty", bus.rsp_dirty, 1'b1);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    check("bank_c_way", bus.rsp_hit_way, 8'b0000_1000);
    check("bank_c_dirty", bus.rsp_dirty, 1'b0);

    // masked write: fill the other ways of set 2, then invalidate way 2 only
    wd = '0;
    for (int w = 0; w < NUM_WAY; w++) begin
      t = 20'($urandom);
      if (t == 20'hABCDE) t = t ^ 20'h1;
      saved[w] = mk_ent(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), t);
      wd[ENT_W*w +: ENT_W] = saved[w];
    end
    wr_req(32'hABCD_E040, 8'b1111_1011, wd);
    wd = '0;
    wd[ENT_W*2 +: ENT_W] = mk_ent(1'b0, 1'b1, 20'hABCDE);
    wr_req(32'hABCD_E040, 8'b0000_0100, wd);
    look_check("masked_lookup", 32'hABCD_E040, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < NUM_WAY; w++)
      check("masked_way", bus.rsp_entries[ENT_W*w +: ENT_W],
            (w == 2) ? mk_ent(1'b0, 1'b1, 20'hABCDE) : saved[w]);

    // multi-hit: dirty must come from the lower way (1)
    wd = '0;
    wd[ENT_W*1 +: ENT_W] = mk_ent(1'b1, 1'b0, 20'h55AA5);
    wd[ENT_W*6 +: ENT_W] = mk_ent(1'b1, 1'b1, 20'h55AA5);
    wr_req(mk_addr(20'h55AA5, 10, 0), 8'b0100_0010, wd);
    look_check("multi", mk_addr(20'h55AA5, 10, 0), 1'b1, 8'b0100_0010, 1'b1, 1'b1, 1'b0);

    // randomised traffic with occasional flush requests
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      f = ($urandom_range(0, 79) == 0);
      if (r < 4)
        drive(1'b1, 1'b1, mk_addr(pick_tag(), pick_set(), int'($urandom_range(0, 31))),
              8'($urandom), rnd_wdata(), f);
      else if (r < 9)
        drive(1'b1, 1'b0, mk_addr(pick_tag(), pick_set(), int'($urandom_range(0, 31))),
              '0, '0, f);
      else
        drive(1'b0, 1'b0, '0, '0, '0, f);
    end

    // flush: populate 10 sets, then one flush pulse
    for (int s = 20; s < 30; s++) begin
      wd = '0;
      wd[ENT_W*0 +: ENT_W] = mk_ent(1'b1, 1'b0, 20'h0F0F0);
      wr_req(mk_addr(20'h0F0F0, s, 0), 8'b0000_0001, wd);
    end
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    @(negedge clk);
    bus.flush_req = 1'b0;
    n = 0; fd = 0;
    while (bus.busy && n < 200) begin n++; fd += int'(bus.flush_done); @(negedge clk); end
    repeat (3) begin fd += int'(bus.flush_done); @(negedge clk); end
    check("flush_cycles", DW'(n), DW'(64));
    check("flush_done_pulses", DW'(fd), DW'(1));
    for (int s = 20; s < 30; s++)
      look_check("post_flush", mk_addr(20'h0F0F0, s, 0), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // reset in the middle of a flush restarts init with no completion pulse
    wd = '0;
    wd[ENT_W*4 +: ENT_W] = mk_ent(1'b1, 1'b1, 20'h0BEEF);
    wr_req(mk_addr(20'h0BEEF, 30, 0), 8'b0001_0000, wd);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    @(negedge clk);
    bus.flush_req = 1'b0;
    fd = 0;
    repeat (29) begin fd += int'(bus.flush_done); @(negedge clk); end
    #2 rst = 1'b0;
    @(negedge clk);
    check("midflush_reset_busy", bus.busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (bus.busy && n < 200) begin n++; fd += int'(bus.flush_done); @(negedge clk); end
    repeat (3) begin fd += int'(bus.flush_done); @(negedge clk); end
    check("reinit_cycles", DW'(n), DW'(64));
    check("reinit_no_flush_done", DW'(fd), DW'(0));
    look_check("post_reinit", mk_addr(20'h0BEEF, 30, 0), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 1'b0, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
